// File: rtl/ring_token_arbiter.sv
// Ring insertion-point arbiter: captures the circulating token, grants it round-robin
// to one local client, muxes that client onto a registered ring output, re-emits the token.
`ifndef Null
`define Null    4'h0
`endif
`ifndef Token
`define Token   4'h1
`endif
`ifndef Message
`define Message 4'h2
`endif

module ringArbLane (
  input  logic        sel,
  input  logic [31:0] data,
  input  logic [3:0]  slotType,
  output logic [31:0] dataMasked,
  output logic [3:0]  typeMasked
);
  assign dataMasked = sel ? data : '0;
  assign typeMasked = sel ? slotType : '0;
endmodule

module ring_token_arbiter #(
  parameter int N_REQ    = 3,
  parameter int MAX_HOLD = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         whichCore,
  input  logic               tokenMaster,
  input  logic [31:0]        RingIn,
  input  logic [3:0]         SlotTypeIn,
  input  logic [3:0]         SourceIn,
  output logic [31:0]        RingOut,
  output logic [3:0]         SlotTypeOut,
  output logic [3:0]         SourceOut,
  input  logic [N_REQ-1:0]   wantsToken,
  input  logic [N_REQ-1:0]   driveRing,
  input  logic [32*N_REQ-1:0] reqRingOut,
  input  logic [4*N_REQ-1:0] reqSlotTypeOut,
  output logic [N_REQ-1:0]   acquireToken,
  output logic               protocolErr
);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, INJECT, HOLD} arbStateT;

  arbStateT        state, nextState;
  logic [2:0]      rr, nextRr, gnt, nextGnt, winner, selIdx;
  logic            winValid, useClient, setErr;
  logic [CW-1:0]   holdCnt, nextCnt;
  logic [N_REQ-1:0] acq, selOneHot;
  logic [31:0]     slotData, muxData;
  logic [3:0]      slotType, slotSrc, muxType;
  logic [N_REQ-1:0][31:0] laneData;
  logic [N_REQ-1:0][3:0]  laneType;

  // first requester at or after rr, wrapping modulo N_REQ
  always_comb begin
    winValid = 1'b0;
    winner   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!winValid && wantsToken[(int'(rr) + k) % N_REQ]) begin
        winValid = 1'b1;
        winner   = 3'((int'(rr) + k) % N_REQ);
      end
    end
  end

  assign selIdx    = (state == HOLD) ? gnt : winner;
  assign selOneHot = N_REQ'(1) << selIdx;

  for (genvar i = 0; i < N_REQ; i++) begin : gLane
    ringArbLane uLane (
      .sel       (selOneHot[i]),
      .data      (reqRingOut[32*i +: 32]),
      .slotType  (reqSlotTypeOut[4*i +: 4]),
      .dataMasked(laneData[i]),
      .typeMasked(laneType[i])
    );
  end

  always_comb begin
    muxData = '0;
    muxType = '0;
    for (int i = 0; i < N_REQ; i++) begin
      muxData |= laneData[i];
      muxType |= laneType[i];
    end
  end

  always_comb begin
    nextState = state;
    nextRr    = rr;
    nextGnt   = gnt;
    nextCnt   = holdCnt;
    setErr    = 1'b0;
    acq       = '0;
    useClient = 1'b0;
    slotData  = RingIn;
    slotType  = SlotTypeIn;
    slotSrc   = SourceIn;
    case (state)
      INJECT: begin
        slotData  = '0;
        slotType  = `Token;
        slotSrc   = whichCore;
        nextState = IDLE;
      end
      IDLE: begin
        if (SlotTypeIn == `Token && winValid) begin
          acq[winner] = 1'b1;
          if (driveRing[winner]) begin
            useClient = 1'b1;
            nextState = HOLD;
            nextGnt   = winner;
            nextRr    = (winner == 3'(N_REQ - 1)) ? 3'd0 : winner + 3'd1;
            nextCnt   = CW'(1);
          end
        end
      end
      HOLD: begin
        // incoming slot is always overwritten; a stray token is thereby discarded
        if (SlotTypeIn != `Null) setErr = 1'b1;
        if (driveRing[gnt] && holdCnt < MAXC) begin
          acq[gnt]  = 1'b1;
          useClient = 1'b1;
          nextCnt   = holdCnt + CW'(1);
        end else begin
          if (driveRing[gnt]) setErr = 1'b1;
          slotData  = '0;
          slotType  = `Token;
          slotSrc   = whichCore;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    if (useClient) begin
      slotData = muxData;
      slotType = muxType;
      slotSrc  = whichCore;
    end
  end

  assign acquireToken = acq & {N_REQ{reset}};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= tokenMaster ? INJECT : IDLE;
      rr          <= '0;
      gnt         <= '0;
      holdCnt     <= '0;
      RingOut     <= '0;
      SlotTypeOut <= `Null;
      SourceOut   <= '0;
      protocolErr <= 1'b0;
    end else begin
      state       <= nextState;
      rr          <= nextRr;
      gnt         <= nextGnt;
      holdCnt     <= nextCnt;
      RingOut     <= slotData;
      SlotTypeOut <= slotType;
      SourceOut   <= slotSrc;
      if (setErr) protocolErr <= 1'b1;
    end
  end
endmodule

// File: doc/ring_token_arbiter.md
# ring_token_arbiter

Per-core ring-access arbiter. It shares this core's single ring insertion point between up to N_REQ local ring clients: the messenger plus optional DMA or display units. Each client uses the messenger-style wantsToken / acquireToken / driveRing handshake. The arbiter captures the circulating token, grants it round-robin, multiplexes the granted client onto the ring, registers the ring output, and re-emits the token when the client stops driving.

## Interface
- N_REQ, 3: number of local ring clients (1..8); index 0 is the messenger.
- MAX_HOLD, 64: maximum cycles a grant may drive the ring (one header plus a 63-word payload).
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- whichCore  in  4  this core's ring ID.
- tokenMaster  in  1  this core injects the initial token after reset; static.
- RingIn / SlotTypeIn / SourceIn  in  32/4/4  upstream ring slot.
- RingOut / SlotTypeOut / SourceOut  out  32/4/4  registered downstream ring slot.
- wantsToken  in  N_REQ  per-client token request (level).
- driveRing  in  N_REQ  per-client "my ring data is valid this cycle".
- reqRingOut  in  32*N_REQ  client ring data; client i occupies bits [32i+31:32i].
- reqSlotTypeOut  in  4*N_REQ  client slot type.
- acquireToken  out  N_REQ  one-hot grant, combinational.
- protocolErr  out  1  sticky error flag; cleared only by reset.

## Operation
- The slot-type encodings `Token, `Null and `Message are the shared ring defines.
- State machine: INJECT (entered at reset only when tokenMaster=1), IDLE, HOLD. A round-robin pointer rr[2:0] resets to 0.
- INJECT: lasts one cycle. Emits a token slot (`Token, data 0, source whichCore), then goes to IDLE.
- IDLE, token arrives (SlotTypeIn==`Token):
  - Winner = first i with wantsToken[i], searching from rr upward modulo N_REQ.
  - acquireToken[winner]=1 in that same cycle.
  - If driveRing[winner]=1, the client's slot replaces the token. State goes to HOLD, gnt<=winner, rr<=winner+1 (mod N_REQ), holdCnt<=1.
  - If driveRing[winner]=0, the token passes through unchanged and the state stays IDLE.
  - If no client wants the token, it passes through.
- IDLE, any other slot: passes through unchanged (RingIn/SlotTypeIn/SourceIn).
- HOLD: acquireToken[gnt] stays 1 for as long as driveRing[gnt]=1.
  - While driveRing[gnt]=1: output is the client's data and slot type, source whichCore. holdCnt increments.
  - First cycle with driveRing[gnt]=0: output a token slot and go to IDLE.
  - If holdCnt reaches MAX_HOLD with driveRing still high: set protocolErr, force token emission, go to IDLE. Any further client data is dropped.
- In HOLD, any incoming SlotTypeIn other than `Null sets protocolErr; that slot is overwritten. Exception: an incoming `Token sets protocolErr and is discarded (duplicate token).
- In HOLD, driveRing from a non-granted client is ignored.

## Timing
- Output register: the slot presented at cycle t (pass-through or client) appears on RingOut at t+1.
- acquireToken is combinational from SlotTypeIn, wantsToken, rr and state.
- Clients must assert driveRing in the acquire cycle and keep it contiguous. One gap ends the grant.
- Token recirculates one cycle after the last client word. Token-in to the next grant on another core takes at least 1 cycle per hop.
- Values during reset (asynchronous assertion): RingOut=0, SlotTypeOut=`Null, SourceOut=0, acquireToken=0, protocolErr=0, rr=0, state=IDLE or INJECT.
- Reset mid-HOLD aborts immediately. The token is re-injected only by the tokenMaster core.

## Test plan
- Reset release with tokenMaster=1, whichCore=2, no wants -> at cycle 1 RingOut={`Token, 0, src 2}. Token passes through on every later lap.
- wantsToken=3'b011, token arrives, client 0 drives header plus 3 words -> acquireToken=001 for 4 cycles. RingOut carries those 4 slots at +1 latency, then `Token. On the next lap client 1 wins (acquireToken=010).
- Winner does not assert driveRing in the acquire cycle -> the token passes through, state stays IDLE, protocolErr=0.
- Client 2 drives for 70 cycles with MAX_HOLD=64 -> token emitted on the output after the 64th slot, protocolErr=1, remaining words dropped.
- During HOLD, inject a `Message slot on SlotTypeIn -> protocolErr=1 and the client data still appears on RingOut. Inject a second `Token -> it is discarded.
- Assert reset (low) in the middle of HOLD -> all outputs reach reset values asynchronously. After release with tokenMaster=0, the core waits for a token from upstream.
